// File: rtl/seq_divider_if.sv
// Operand/result bundle for seq_divider: start request with operands, and the
// registered quotient, remainder and status flags coming back.
interface seq_divider_if;
    logic       start;
    logic [5:0] N;
    logic [2:0] D;
    logic [5:0] Q;
    logic [2:0] R;
    logic       busy;
    logic       done;
    logic       dbz;

    modport master (
        output start, N, D,
        input  Q, R, busy, done, dbz
    );

    modport slave (
        input  start, N, D,
        output Q, R, busy, done, dbz
    );
endinterface

// File: rtl/seq_divider.sv
// 6-bit by 3-bit restoring divider, one quotient bit per cycle, MSB first.
// Fixed latency; a zero divisor skips the iterations and reports dbz.
module seq_divider (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StCalc = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0] state_q, state_d;
    logic [5:0] dvd_q, dvd_d;
    logic [2:0] dvs_q, dvs_d;
    logic [3:0] rem_q, rem_d;
    logic [5:0] quo_q, quo_d;
    logic [2:0] cnt_q, cnt_d;
    logic [5:0] q_q, q_d;
    logic [2:0] r_q, r_d;
    logic       dbz_q, dbz_d;

    logic [4:0] rem_shift;
    logic [3:0] rem_sub;
    logic       fits;

    // One restoring step on the current partial remainder.
    always_comb begin
        rem_shift = {rem_q, dvd_q[5]};
        fits      = rem_shift >= {2'b00, dvs_q};
        rem_sub   = rem_shift[3:0] - {1'b0, dvs_q};
    end

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    dvd_d = bus.N;
                    dvs_d = bus.D;
                    rem_d = 4'd0;
                    quo_d = 6'd0;
                    cnt_d = 3'd5;
                    if (bus.D == 3'd0) begin
                        state_d = StDone;
                        q_d     = 6'h3F;
                        r_d     = 3'd0;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                dvd_d = {dvd_q[4:0], 1'b0};
                rem_d = fits ? rem_sub : rem_shift[3:0];
                quo_d = {quo_q[4:0], fits};
                if (cnt_q == 3'd0) begin
                    state_d = StDone;
                    q_d     = quo_d;
                    r_d     = rem_d[2:0];
                    dbz_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            dvd_q   <= 6'd0;
            dvs_q   <= 3'd0;
            rem_q   <= 4'd0;
            quo_q   <= 6'd0;
            cnt_q   <= 3'd0;
            q_q     <= 6'd0;
            r_q     <= 3'd0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.Q    = q_q;
    assign bus.R    = r_q;
    assign bus.dbz  = dbz_q;
    assign bus.busy = (state_q == StCalc);
    assign bus.done = (state_q == StDone);

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 start  input  1  operation request; sampled only in IDLE.
REQ-005 N  input  6  unsigned dividend; captured on the start-accept edge.
REQ-006 D  input  3  unsigned divisor; captured on the start-accept edge.
REQ-007 Q  output  6  unsigned quotient, registered.
REQ-008 R  output  3  unsigned remainder, registered.
REQ-009 busy  output  1  high while a division is in progress.
REQ-010 done  output  1  one-cycle pulse; Q/R/dbz valid and updated.
REQ-011 dbz  output  1  divide-by-zero flag for the last completed operation.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-013 In IDLE with start=1, the block SHALL latch N and D, clear the partial remainder (4 bits internal), load a 3-bit iteration counter with 5, and go to CALC; if D=0, it SHALL go directly to DONE instead.
REQ-014 In IDLE with start=0, the state and all outputs SHALL hold.
REQ-015 Each CALC cycle SHALL run one restoring step: shift the MSB of the dividend register into the partial remainder; if partial remainder >= D, subtract D and shift in quotient bit 1, else shift in 0.
REQ-016 CALC SHALL last exactly 6 cycles, one per dividend bit, MSB first; after the step with counter=0 the FSM SHALL go to DONE. Otherwise the counter SHALL decrement.
REQ-017 Q, R and dbz SHALL update only on the edge entering DONE, and SHALL hold until the next DONE entry or reset.
REQ-018 Normal results SHALL satisfy N = Q*D + R with R < D.
REQ-019 On divide-by-zero, the block SHALL set Q=6'h3F, R=3'd0 and dbz=1; done SHALL assert one cycle after the start-accept edge, with no CALC cycles.
REQ-020 On any non-zero-divisor completion, the block SHALL clear dbz to 0.
REQ-021 done SHALL be high only in DONE, for exactly one cycle, after which the FSM SHALL return to IDLE unconditionally.
REQ-022 busy SHALL be high only in CALC and low in IDLE and DONE.
REQ-023 Latency SHALL be fixed: done rises 7 edges after the start-accept edge for D!=0, and 1 edge after it for D=0.
REQ-024 start asserted in CALC or DONE SHALL be ignored without queuing; a start held high SHALL be accepted on the first IDLE cycle after DONE.
REQ-025 Changes on N or D after the start-accept edge SHALL NOT affect the operation in progress.

Reset
REQ-026 rst=1 SHALL force IDLE and drive Q=0, R=0, busy=0, done=0, dbz=0 on the same edge, clearing all internal registers.
REQ-027 rst SHALL take priority over start and SHALL abort any operation in CALC or DONE; an aborted operation SHALL produce no done pulse.
REQ-028 After rst is released, the block SHALL accept start on the first edge.

Verification
REQ-029 N=45, D=5, start pulse -> busy for 6 cycles, done 7 edges later, Q=9, R=0, dbz=0.
REQ-030 N=13, D=7 -> Q=1, R=6; N=2, D=7 -> Q=0, R=2; N=63, D=1 -> Q=63, R=0.
REQ-031 N=5, D=0 -> done 1 edge after accept, Q=63, R=0, dbz=1, busy never high; a following N=6, D=3 -> Q=2, R=0, dbz=0.
REQ-032 start re-asserted with N=60, D=4 during CALC of N=45, D=5 -> result Q=9, R=0 only, with a single done pulse.
REQ-033 rst at the 3rd CALC cycle -> next cycle state IDLE, all outputs 0, no done; a new N=21, D=3 then yields Q=7, R=0.
REQ-034 Exhaustive sweep of all 64x8 operand pairs against N = Q*D + R, R < D, with the D=0 rule of REQ-019 and latency checked on every operation.
